sseg_scan_driver: RTL
=====================

Name: sseg_scan_driver

Overview:
- Downstream consumer of the processor's 24-bit seven-segment output bus (three 8-bit segment bytes written via ports 0x40, 0x20 and 0x10).
- Time-multiplexes the three bytes onto one shared cathode bus and three digit anodes.
- Adds an inter-digit blanking gap (anti-ghosting), 16-level brightness PWM, and a per-frame shadow snapshot so firmware writes never tear mid-frame.

Parameters:
- DIGIT_PERIOD, 50000: clk cycles per digit slot (1 ms at 50 MHz).
- BLANK_CYCLES, 480: cycles at the start of each digit slot with everything dark. Constraint: DIGIT_PERIOD-BLANK_CYCLES must be a nonzero multiple of 16.
- SEG_ACTIVE_LOW, 1: 1 means seg_out is driven low to light a segment.
- AN_ACTIVE_LOW, 1: 1 means an_out is driven low to select a digit.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sseg_in  input  24  segment patterns, 1 = lit, bit order {dp,g,f,e,d,c,b,a}; digit0=[7:0], digit1=[15:8], digit2=[23:16]
- brightness  input  4  duty level 0..15, sampled only at snapshot
- enable  input  1  scanning enable, level sensitive
- seg_out  output  8  cathode drive, polarity per SEG_ACTIVE_LOW
- an_out  output  3  anode drive, an_out[d] selects digit d, polarity per AN_ACTIVE_LOW
- frame_tick  output  1  one-cycle pulse at end of each complete 3-digit frame

Behaviour:
- Reset (async, active-high) forces:
  - seg_out and an_out to the inactive level (8'hFF and 3'b111 with default polarities).
  - frame_tick=0, shadow registers=0, digit index=0, cycle counter=0, state=IDLE.
- States:
  - IDLE: outputs inactive; counter held at 0.
  - SCAN: counter cnt runs 0..DIGIT_PERIOD-1 for the current digit d (0,1,2).
- IDLE->SCAN on the first clk edge with enable=1. On that edge:
  - sseg_in and brightness load into the shadows.
  - d=0, cnt=0.
- SCAN->IDLE on any edge with enable=0, including mid-digit. Outputs go inactive on that edge; no frame_tick is issued.
- In SCAN, each edge:
  - cnt increments.
  - At cnt=DIGIT_PERIOD-1, cnt wraps to 0 and d advances 0->1->2->0.
  - At the d=2 wrap, the shadows reload from the current sseg_in and brightness, and frame_tick=1 for exactly that cycle.
- Per-cycle decode, with SLOT=(DIGIT_PERIOD-BLANK_CYCLES)/16:
  - cnt<BLANK_CYCLES: all anodes and all segments inactive.
  - Otherwise slot=(cnt-BLANK_CYCLES)/SLOT (integer divide, range 0..15). Only an_out[d] is active, and only when slot<=brightness_shadow.
  - seg_out shows shadow byte d whenever its anode is active, and is inactive otherwise.
- Latency: seg_out, an_out and frame_tick are registered, so each appears one cycle after the cnt/d value that produced it.
- At most one anode is active in any cycle. Segments and anode change together, so there is never a cycle showing a new pattern on the old digit.
- Changes to sseg_in or brightness between snapshots have no visible effect until the next frame boundary.
- brightness=15 gives the full drive window. brightness=0 gives exactly SLOT active cycles per digit.
- A counter needs ceil(log2(DIGIT_PERIOD)) bits; no other arithmetic may overflow.

Test Plan:
All scenarios use DIGIT_PERIOD=40, BLANK_CYCLES=8 (so SLOT=2), default polarities.
1. Basic scan: sseg_in=24'h3F065B, brightness=15, enable=1.
   - Each digit: 8 dark cycles, then 32 cycles of an_out=3'b110 with seg_out=8'hA4 (digit0).
   - Then 8 dark cycles and 32 cycles of 3'b101 with 8'hF9 (digit1).
   - Then 8 dark cycles and 32 cycles of 3'b011 with 8'hC0 (digit2).
   - frame_tick pulses every 120 cycles.
2. Brightness: brightness=0 -> anode active exactly 2 cycles per digit. brightness=7 -> 16 cycles. Check this for every digit.
3. No tearing: change sseg_in to 24'h000000 during digit1 -> digit1 and digit2 still show old patterns (8'hF9, 8'hC0); blank patterns (8'hFF) appear from the next frame's digit0.
4. Enable drop: deassert enable at cnt=20 of digit1 -> next cycle seg_out=8'hFF, an_out=3'b111, no frame_tick. Reassert -> scan restarts at digit0 blank gap with a fresh snapshot.
5. Async reset mid-drive: assert reset between clk edges while an_out=3'b110 -> outputs go inactive immediately, with no clk edge. After release and enable=1 -> scan restarts at digit0.
6. One-hot check over 10 frames with random sseg_in and brightness -> an_out never has more than one active bit.

Source files
------------

// File: rtl/sseg_scan_driver.sv
// Three-digit seven-segment scan driver with an inter-digit blanking gap, 16-level PWM
// brightness and a per-frame shadow snapshot of the segment patterns.
module sseg_scan_driver #(
   parameter int DIGIT_PERIOD   = 50000,
   parameter int BLANK_CYCLES   = 480,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] sseg_in,
   input  logic [3:0]  brightness,
   input  logic        enable,
   output logic [7:0]  seg_out,
   output logic [2:0]  an_out,
   output logic        frame_tick
);

   localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
   localparam int SLOT = (DIGIT_PERIOD - BLANK_CYCLES) / 16;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_PERIOD - 1);
   localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [2:0] AN_OFF = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic [1:0]      digit, digit_next;
   logic [23:0]     seg_shadow;
   logic [3:0]      bright_shadow;
   logic            load_shadow;
   logic [7:0]      seg_next;
   logic [2:0]      an_next;
   logic            tick_next;
   logic [7:0]      cur_byte;
   logic            lit;
   int              cnt_i;

   // The drive window is the first (brightness+1) PWM slots after the blanking gap,
   // which is the same as asking whether (cnt-BLANK)/SLOT <= brightness.
   always_comb begin
      cnt_i = int'(cnt);
      lit = (cnt_i >= BLANK_CYCLES) &&
            (cnt_i < BLANK_CYCLES + (int'(bright_shadow) + 1) * SLOT);
      case (digit)
         2'd0:    cur_byte = seg_shadow[7:0];
         2'd1:    cur_byte = seg_shadow[15:8];
         default: cur_byte = seg_shadow[23:16];
      endcase
   end

   // Next-state and next-output logic; segments and anode are produced together so a
   // pattern can never appear on the wrong digit.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      digit_next  = digit;
      load_shadow = 1'b0;
      seg_next    = SEG_OFF;
      an_next     = AN_OFF;
      tick_next   = 1'b0;
      case (state)
         IDLE: begin
            cnt_next   = '0;
            digit_next = 2'd0;
            if (enable) begin
               state_next  = SCAN;
               load_shadow = 1'b1;
            end
         end
         SCAN: begin
            if (!enable) begin
               state_next = IDLE;
               cnt_next   = '0;
               digit_next = 2'd0;
            end else begin
               if (lit) begin
                  seg_next       = SEG_ACTIVE_LOW ? ~cur_byte : cur_byte;
                  an_next[digit] = ~AN_OFF[0];
               end
               if (cnt == CNT_LAST) begin
                  cnt_next = '0;
                  if (digit == 2'd2) begin
                     digit_next  = 2'd0;
                     load_shadow = 1'b1;
                     tick_next   = 1'b1;
                  end else begin
                     digit_next = digit + 2'd1;
                  end
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // All state and the output drivers are registered, giving one cycle of latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         digit         <= 2'd0;
         seg_shadow    <= 24'h000000;
         bright_shadow <= 4'h0;
         seg_out       <= SEG_OFF;
         an_out        <= AN_OFF;
         frame_tick    <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         digit      <= digit_next;
         seg_out    <= seg_next;
         an_out     <= an_next;
         frame_tick <= tick_next;
         if (load_shadow) begin
            seg_shadow    <= sseg_in;
            bright_shadow <= brightness;
         end
      end
   end

endmodule
